// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_BURST = 2;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO write port between two producers.
// Handshake: a word moves on any cycle where the owner's req is high and fifoFull is low.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BURST = DEF_BURST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dataIn1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             accept0,
  output logic             accept1,
  input  logic             fifoFull,
  output logic             fifoWrite,
  output logic [WIDTH-1:0] fifoDataIn
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ptr, ptr_n;

  logic             own_req, oth_req, own_acc, oth_id;
  arb_state_t       oth_state;

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  // The reset cycle never writes, even if an owner is mid-burst.
  assign accept0    = gnt0 & req0 & ~fifoFull & ~reset;
  assign accept1    = gnt1 & req1 & ~fifoFull & ~reset;
  assign fifoWrite  = accept0 | accept1;
  assign fifoDataIn = gnt1 ? dataIn1 : dataIn0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    own_req   = gnt1 ? req1 : req0;
    oth_req   = gnt1 ? req0 : req1;
    own_acc   = accept0 | accept1;
    oth_state = gnt1 ? OWN0 : OWN1;
    oth_id    = gnt0;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_n = ptr ? OWN1 : OWN0;
        else if (req0)     state_n = OWN0;
        else if (req1)     state_n = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_n = oth_req ? oth_state : IDLE;
          ptr_n   = oth_id;
          cnt_n   = '0;
        end else if (own_acc) begin
          if (cnt == LAST) begin
            // Burst limit only forces a handover when someone is waiting.
            cnt_n = '0;
            if (oth_req) begin
              state_n = oth_state;
              ptr_n   = oth_id;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter with a write-data scoreboard.
module tb_fifo_write_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, fifoFull;
  logic [W-1:0] dataIn0, dataIn1;
  logic         gnt0, gnt1, accept0, accept1, fifoWrite;
  logic [W-1:0] fifoDataIn;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst, r0, r1, full;
    logic [W-1:0] d0, d1;
    logic         g0, g1, a0, a1, wr;
    logic [W-1:0] dat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(W), .BURST(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .dataIn0(dataIn0),
    .req1(req1), .dataIn1(dataIn1),
    .gnt0(gnt0), .gnt1(gnt1),
    .accept0(accept0), .accept1(accept1),
    .fifoFull(fifoFull), .fifoWrite(fifoWrite), .fifoDataIn(fifoDataIn)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, r0, r1, full, input logic [W-1:0] d0, d1,
                     input logic g0, g1, a0, a1, wr, input logic [W-1:0] dat);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.full = full; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.a0 = a0; v.a1 = a1; v.wr = wr; v.dat = dat;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, r0, r1, full, input logic [W-1:0] d0, d1);
    reset = rst; req0 = r0; req1 = r1; fifoFull = full; dataIn0 = d0; dataIn1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (fifoWrite === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got write %0h expected none at %0t", fifoDataIn, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (fifoDataIn !== e) begin
          bad++;
          $display("FAIL sb_data: got %0h expected %0h at %0t", fifoDataIn, e, $time);
        end
      end
    end
  end

  initial begin
    // rst r0 r1 full d0 d1 | g0 g1 a0 a1 wr dat
    // idle after reset
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 8'd0);
    // both producers, burst of 2: P0,P0,P1,P1,P0
    add(0, 1, 1, 0, 8'd10, 8'd20, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'd10, 8'd20, 1, 0, 1, 0, 1, 8'd10);
    add(0, 1, 1, 0, 8'd11, 8'd20, 1, 0, 1, 0, 1, 8'd11);
    add(0, 1, 1, 0, 8'd12, 8'd20, 0, 1, 0, 1, 1, 8'd20);
    add(0, 1, 1, 0, 8'd12, 8'd21, 0, 1, 0, 1, 1, 8'd21);
    add(0, 1, 1, 0, 8'd12, 8'd22, 1, 0, 1, 0, 1, 8'd12);
    add(0, 1, 1, 0, 8'd13, 8'd22, 1, 0, 1, 0, 1, 8'd13);
    // producer 1 owns; full stalls it with count held at 1
    add(0, 0, 1, 0, 8'd0,  8'd22, 0, 1, 0, 1, 1, 8'd22);
    add(0, 1, 1, 1, 8'd14, 8'd23, 0, 1, 0, 0, 0, 8'd0);
    add(0, 1, 1, 1, 8'd14, 8'd23, 0, 1, 0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'd14, 8'd23, 0, 1, 0, 1, 1, 8'd23);
    add(0, 1, 0, 0, 8'd14, 8'd0,  1, 0, 1, 0, 1, 8'd14);
    // reset while producer 0 owns with count 1
    add(1, 1, 1, 0, 8'd15, 8'd30, 1, 0, 0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'd15, 8'd30, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 8'd15, 8'd30, 1, 0, 1, 0, 1, 8'd15);
    add(0, 1, 1, 0, 8'd16, 8'd30, 1, 0, 1, 0, 1, 8'd16);
    // producer 1 alone: burst limit re-arms, no handover
    add(0, 0, 1, 0, 8'd0,  8'd30, 0, 1, 0, 1, 1, 8'd30);
    add(0, 0, 1, 0, 8'd0,  8'd31, 0, 1, 0, 1, 1, 8'd31);
    add(0, 0, 1, 0, 8'd0,  8'd32, 0, 1, 0, 1, 1, 8'd32);
    add(0, 1, 0, 0, 8'd17, 8'd0,  0, 1, 0, 0, 0, 8'd0);
    add(0, 1, 0, 0, 8'd17, 8'd0,  1, 0, 1, 0, 1, 8'd17);
    add(0, 0, 0, 0, 8'd0,  8'd0,  1, 0, 0, 0, 0, 8'd0);
    add(0, 0, 0, 0, 8'd0,  8'd0,  0, 0, 0, 0, 0, 8'd0);

    drive(1, 0, 0, 0, 8'd0, 8'd0);
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_gnt0", {31'd0, gnt0}, 32'd0);
    chk("reset_gnt1", {31'd0, gnt1}, 32'd0);
    chk("reset_write", {31'd0, fifoWrite}, 32'd0);
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].full, vecs[i].d0, vecs[i].d1);
      if (vecs[i].wr) exp_q.push_back(vecs[i].dat);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d_acc0", i), {31'd0, accept0}, {31'd0, vecs[i].a0});
      chk($sformatf("v%0d_acc1", i), {31'd0, accept1}, {31'd0, vecs[i].a1});
      chk($sformatf("v%0d_write", i), {31'd0, fifoWrite}, {31'd0, vecs[i].wr});
      next_cycle();
    end

    // Grant is taken while the FIFO is full, and the word waits for space.
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 1, 8'd40, 8'd0);
      @(negedge clk);
      chk($sformatf("full_idle%0d_gnt0", c), {31'd0, gnt0}, (c == 0) ? 32'd0 : 32'd1);
      chk($sformatf("full_idle%0d_write", c), {31'd0, fifoWrite}, 32'd0);
      next_cycle();
    end
    drive(0, 1, 0, 0, 8'd40, 8'd0);
    exp_q.push_back(8'd40);
    @(negedge clk);
    chk("full_release_write", {31'd0, fifoWrite}, 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("final_gnt0", {31'd0, gnt0}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the team's 8-bit FIFO between two producers.
- Uses round-robin ownership with a per-grant burst limit.
- Sits directly in front of the fifo write/dataIn/full pins. The read side of the FIFO is untouched.
- Producers use a req/gnt handshake; a word transfers on any cycle where the owning producer's req is high and the FIFO is not full.

Parameters:
- WIDTH, 8, data word width; matches the fifo dataIn/dataOut width.
- BURST, 2, max words accepted from one owner per grant while the other producer is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  producer 0 has a word on dataIn0 (level; held until accepted).
- dataIn0  in  WIDTH  producer 0 write data.
- req1  in  1  producer 1 request.
- dataIn1  in  WIDTH  producer 1 write data.
- gnt0  out  1  producer 0 owns the write port (registered).
- gnt1  out  1  producer 1 owns the write port (registered).
- accept0  out  1  producer 0 word taken this cycle (combinational).
- accept1  out  1  producer 1 word taken this cycle (combinational).
- fifoFull  in  1  FIFO full flag.
- fifoWrite  out  1  FIFO write strobe (combinational).
- fifoDataIn  out  WIDTH  FIFO write data.

Behaviour:
- States: IDLE, OWN0, OWN1.
  - gnt0 = (state==OWN0); gnt1 = (state==OWN1); never both high.
- Reset, sampled at a clk edge:
  - state=IDLE, gnt0=gnt1=0, burst counter=0, priority pointer=0 (producer 0 favoured next).
  - Reset mid-burst drops the grant on the next edge; no write occurs in the reset cycle.
- Accept rules:
  - acceptN = gntN & reqN & ~fifoFull.
  - fifoWrite = accept0 | accept1.
  - fifoDataIn = dataIn1 when gnt1, else dataIn0.
  - Zero-cycle path from req/fifoFull to fifoWrite.
- IDLE:
  - No requests: stay.
  - One request: go to that OWN state.
  - Both requests: go to OWN(pointer).
  - Grant latency is 1 cycle from the first req seen in IDLE; the first word transfers on the cycle gnt is high.
- OWNn, evaluated at each edge, in priority order:
  1. reqn low: go to OWN(other) if the other producer's req is high, else IDLE. Pointer = other. Counter = 0.
  2. acceptn and counter==BURST-1 and other req high: go to OWN(other). Pointer = other. Counter = 0.
  3. acceptn and counter==BURST-1 and other req low: stay, counter = 0 (burst limit re-arms).
  4. acceptn otherwise: stay, counter + 1.
  5. No accept (fifoFull): stay, counter holds. The grant is never revoked because of full.
- Counter width is 4 bits and it never exceeds BURST-1.
- The owner dropping req on the same cycle as its final accept follows rule 1; the accepted word is still written.
- Handover is one edge: the new owner can write in the very next cycle, with no idle bubble.
- A producer must hold req and data stable until it sees acceptN. The arbiter never drops a presented word.

Decomposition:
- Shared package fifo_pkg holds:
  - state enum (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - default WIDTH=8 and BURST=2;
  - counter width constant CNT_W=4.
- Single module; no sub-module is warranted.
- Bench instantiates this block plus the existing fifo, with fifo.write/dataIn driven from fifoWrite/fifoDataIn and fifo.full fed back to fifoFull.

Test Plan:
1. reset high 2 cycles, then low with req0=req1=0 -> gnt0=gnt1=0 and fifoWrite=0 for 5 cycles; on reset, IDLE.
2. req0=1, dataIn0=8'd1, then 8'd3 on acceptance; req1=0 -> gnt0 high 1 cycle after req0; fifoWrite pulses with data 1 then 3; gnt0 stays while req0 held.
3. req0 and req1 both held, BURST=2, FIFO empty -> accept pattern P0,P0,P1,P1,P0 on consecutive cycles with no bubble; first owner is producer 0.
4. fifoFull=1 while gnt1 high and req1=1 -> fifoWrite=0, gnt1 held, counter held; deassert fifoFull -> word accepted the same cycle, burst resumes from the held count.
5. Producer 0 owns with counter=1, and reset is asserted mid-operation -> next edge gnt0=0, state IDLE; after release, a simultaneous req0/req1 grants producer 0 first.
6. req1 only, 3 words at BURST=2 -> accepts 3 consecutive cycles with no handover (counter re-arms); then req1=0 and req0=1 -> gnt1 low, gnt0 high on the same edge.
